// File: rtl/fifo_beat_reader_pkg.sv
// Shared types and defaults for the FIFO beat reader slice.
package fifo_beat_reader_pkg;

    localparam int DEF_IN_WIDTH  = 512;
    localparam int DEF_OUT_WIDTH = 32;
    localparam int DEF_CNT_WIDTH = 32;

    // Reader occupancy: idle (nothing loaded) or holding an entry being serialized.
    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_HOLD = 1'b1
    } rd_state_t;

    // Beat counter width; a single-beat entry still needs a 1-bit counter.
    function automatic int beat_width(input int ratio);
        return (ratio <= 1) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/fifo_beat_reader_if.sv
// FIFO read port plus narrow beat stream seen by the reader.
interface fifo_beat_reader_if
    import fifo_beat_reader_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
);
    logic [IN_WIDTH-1:0]  i_fifo_data;
    logic                 i_fifo_empty;
    logic                 o_fifo_ren;
    logic                 o_valid;
    logic                 i_ready;
    logic [OUT_WIDTH-1:0] o_data;
    logic                 o_last;

    // Reader side: consumes the FIFO head, produces beats.
    modport master (
        input  i_fifo_data, i_fifo_empty, i_ready,
        output o_fifo_ren, o_valid, o_data, o_last
    );

    // Environment side: FIFO and beat consumer.
    modport slave (
        output i_fifo_data, i_fifo_empty, i_ready,
        input  o_fifo_ren, o_valid, o_data, o_last
    );
endinterface

// File: rtl/fifo_beat_reader_syncfifo.sv
// SyncFIFO: synchronous FIFO with combinational head data. The read pointer
// is not guarded against underflow; the reader must never pop while empty.
module SyncFIFO #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_wen,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_ren,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [ADDR_WIDTH-1:0] o_raddr
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [CW-1:0]         r_count;
    logic                  w_we;

    assign w_we    = i_wen && !o_full;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_rdata = r_mem[r_raddr];
    assign o_raddr = r_raddr;

    // Storage array: written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (!i_rst && w_we) begin
            r_mem[r_waddr] <= i_wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_waddr <= '0;
            r_raddr <= '0;
            r_count <= '0;
        end else begin
            if (w_we) begin
                r_waddr <= r_waddr + ADDR_WIDTH'(1);
            end
            if (i_ren) begin
                r_raddr <= r_raddr + ADDR_WIDTH'(1);
            end
            case ({w_we, i_ren})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/fifo_beat_reader.sv
// fifo_beat_reader: pops wide FIFO entries and emits them as narrow
// valid/ready beats, LSB first, flagging the final beat of each entry.
module fifo_beat_reader
    import fifo_beat_reader_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_rst,
    fifo_beat_reader_if.master    bus,
    output logic [CNT_WIDTH-1:0]  o_pop_cnt
);
    localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = beat_width(RATIO);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    if (IN_WIDTH % OUT_WIDTH != 0) begin : g_width_check
        $error("fifo_beat_reader: IN_WIDTH (%0d) is not a multiple of OUT_WIDTH (%0d)",
               IN_WIDTH, OUT_WIDTH);
    end

    rd_state_t             r_state;
    logic [IN_WIDTH-1:0]   r_sreg;
    logic [BEAT_W-1:0]     r_beat;
    logic [CNT_WIDTH-1:0]  r_pop_cnt;

    logic w_hold;
    logic w_last;
    logic w_fire;
    logic w_done;
    logic w_ren;

    assign w_hold = (r_state == RD_HOLD);
    assign w_last = w_hold && (r_beat == LAST_BEAT);
    assign w_fire = w_hold && bus.i_ready;
    assign w_done = w_fire && w_last;
    // Refill only when idle or the final beat leaves this cycle, and never on empty.
    assign w_ren  = !i_rst && !bus.i_fifo_empty && (!w_hold || w_done);

    assign bus.o_fifo_ren = w_ren;
    assign bus.o_valid    = w_hold;
    assign bus.o_data     = r_sreg[OUT_WIDTH-1:0];
    assign bus.o_last     = w_last;
    assign o_pop_cnt      = r_pop_cnt;

    // Load on pop, shift on accepted non-final beat, release on final beat.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state   <= RD_IDLE;
            r_sreg    <= '0;
            r_beat    <= '0;
            r_pop_cnt <= '0;
        end else if (w_ren) begin
            r_state   <= RD_HOLD;
            r_sreg    <= bus.i_fifo_data;
            r_beat    <= '0;
            r_pop_cnt <= r_pop_cnt + CNT_WIDTH'(1);
        end else if (w_fire && !w_last) begin
            r_sreg    <= r_sreg >> OUT_WIDTH;
            r_beat    <= r_beat + BEAT_W'(1);
        end else if (w_done) begin
            r_state   <= RD_IDLE;
        end
    end
endmodule
